bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 185 ++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Streams a run of consecutive RAM words out of a 2-cycle-latency block RAM
// read port. A command gives a start address and a word count; reads are
// issued only while the output buffer has room for every word already
// requested, so a stalled consumer never causes data to be dropped.
module bram_stream_reader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 9,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_regce,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        pipe_valid;
    logic [1:0]        pipe_last;
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              done_q;

    logic              cmd_fire;
    logic              issue;
    logic              issue_last;
    logic              push;
    logic              pop;
    logic [1:0]        in_flight;
    logic [OCC_W-1:0]  occupancy;
    logic [DATA_W:0]   fifo_head;

    // Credit check: a word is requested only when the buffer can hold it
    // together with everything already in flight from the RAM.
    assign in_flight  = {1'b0, pipe_valid[0]} + {1'b0, pipe_valid[1]};
    assign occupancy  = {1'b0, fifo_count} + OCC_W'(in_flight);
    assign issue      = (state == RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
    assign issue_last = issue && (remaining == LEN_W'(1));
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign push       = pipe_valid[1];
    assign pop        = m_valid && m_ready;

    assign fifo_head  = fifo_mem[rd_ptr];
    assign m_valid    = (fifo_count != '0);
    assign m_data     = fifo_head[DATA_W-1:0];
    assign m_last     = m_valid && fifo_head[DATA_W];

    assign ram_addr   = cur_addr;
    assign ram_en     = issue;
    assign ram_we     = 1'b0;
    assign ram_regce  = 1'b1;
    assign done       = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a command is refused during the done pulse cycle.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = !done_q;
                if (cmd_valid && !done_q && (cmd_len != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, then step address (wrapping) and remaining count per read.
    always_ff @(posedge clk) begin
        if (rstb) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
        end else if (issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Two-stage tracker lining each request up with its RAM data; clearing
    // it on reset keeps late RAM data out of the buffer.
    always_ff @(posedge clk) begin
        if (rstb) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
        end else begin
            pipe_valid <= {pipe_valid[0], issue};
            pipe_last  <= {pipe_last[0], issue_last};
        end
    end

    // Buffer storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pipe_last[1], ram_dout};
        end
    end

    // Buffer pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Completion pulse: after an empty command, or after the final beat leaves.
    always_ff @(posedge clk) begin
        if (rstb) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (cmd_fire && (cmd_len == '0)) ||
                      ((state == DRAIN) && pop && m_last);
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a 2-cycle-latency RAM model holding
// mem[i]=i, a queue of expected beats built from each accepted command, and
// directed plus randomized commands with random consumer back-pressure.
module tb_bram_stream_reader;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 9;
    localparam int LEN_W      = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_SIZE   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstb = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic              ram_we;
    logic              ram_regce;
    logic [DATA_W-1:0] ram_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state
    logic [DATA_W-1:0] mem [MEM_SIZE];
    logic [DATA_W-1:0] ram_s1;
    logic [DATA_W-1:0] ram_s2;
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W:0]   head;
    logic [DATA_W:0]   beat;
    logic [DATA_W-1:0] held_data;
    logic              held_last;
    bit   mon_en = 1'b0;
    bit   cmd_busy = 1'b0;
    bit   done_due = 1'b0;
    bit   exp_done;
    bit   hold_pending = 1'b0;
    bit   first_pending = 1'b0;
    bit   last_pop;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   hs_addr = 0;
    int   cmd_len_m = 0;
    int   reads_in_cmd = 0;
    int   reads_cnt = 0;
    int   pops_cnt = 0;
    int   done_cnt = 0;
    int   last_cnt = 0;
    int   valid_cnt = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;
    int   ready_mode = 0;

    bram_stream_reader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .ram_addr(ram_addr),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_regce(ram_regce),
        .ram_dout(ram_dout),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .busy(busy),
        .done(done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // RAM model: address sampled on an enabled edge, data visible two cycles on.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_s1 <= mem[ram_addr];
        end
        ram_s2 <= ram_s1;
    end
    assign ram_dout = ram_s2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic resetCounters();
        reads_cnt = 0;
        pops_cnt  = 0;
        done_cnt  = 0;
        last_cnt  = 0;
        valid_cnt = 0;
    endtask

    // Offers one command and returns once it has been accepted.
    task automatic applyStimulus(input int addr, input int len);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt >= n) begin
                break;
            end
        end
        repeat (4) @(posedge clk);
        checkOutput("done_count", 32'(done_cnt), 32'(n));
    endtask

    // Consumer: always ready, random, or stalled.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 1) == 1);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (rstb) begin
                exp_q.delete();
                cmd_busy      = 1'b0;
                done_due      = 1'b0;
                hold_pending  = 1'b0;
                first_pending = 1'b0;
                cmd_len_m     = 0;
                reads_in_cmd  = 0;
            end else begin
                exp_done = done_due;
                checkOutput("done", 32'(done), 32'(exp_done));
                checkOutput("busy", 32'(busy), 32'(cmd_busy));
                checkOutput("cmd_ready", 32'(cmd_ready), 32'(!cmd_busy && !exp_done));
                if (done) begin
                    done_cnt++;
                end
                if (hold_pending) begin
                    checkOutput("stall_valid", 32'(m_valid), 32'd1);
                    checkOutput("stall_data", 32'(m_data), 32'(held_data));
                    checkOutput("stall_last", 32'(m_last), 32'(held_last));
                end
                if (ram_en) begin
                    checkOutput("read_allowed", 32'(cmd_busy && (reads_in_cmd < cmd_len_m)), 32'd1);
                    checkOutput("ram_addr", 32'(ram_addr), 32'((hs_addr + reads_in_cmd) % MEM_SIZE));
                    reads_in_cmd++;
                    reads_cnt++;
                end
                // A command accepted in cycle c issues its first read in c+1,
                // whose data lands in the buffer at the end of c+3.
                if (m_valid) begin
                    valid_cnt++;
                    if (first_pending) begin
                        checkOutput("first_valid_latency", 32'(cyc - hs_cyc), 32'd4);
                        first_pending = 1'b0;
                    end
                end
                last_pop = 1'b0;
                if (m_valid && (exp_q.size() == 0)) begin
                    checkOutput("m_valid_extra", 32'(m_valid), 32'd0);
                end else if (m_valid && m_ready) begin
                    head = exp_q.pop_front();
                    checkOutput("m_data", 32'(m_data), 32'(head[DATA_W-1:0]));
                    checkOutput("m_last", 32'(m_last), 32'(head[DATA_W]));
                    if (pops_cnt == 0) begin
                        first_pop_cyc = cyc;
                    end
                    last_pop_cyc = cyc;
                    pops_cnt++;
                    if (m_last) begin
                        last_cnt++;
                    end
                    last_pop = head[DATA_W];
                end
                hold_pending = m_valid && !m_ready;
                held_data    = m_data;
                held_last    = m_last;

                done_due = 1'b0;
                if (last_pop) begin
                    done_due = 1'b1;
                    cmd_busy = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    hs_addr      = int'(cmd_addr);
                    cmd_len_m    = int'(cmd_len);
                    reads_in_cmd = 0;
                    hs_cyc       = cyc;
                    for (int i = 0; i < cmd_len_m; i++) begin
                        beat = {(i == cmd_len_m - 1), mem[(hs_addr + i) % MEM_SIZE]};
                        exp_q.push_back(beat);
                    end
                    if (cmd_len_m == 0) begin
                        done_due = 1'b1;
                    end else begin
                        cmd_busy      = 1'b1;
                        first_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] = DATA_W'(i);
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(m_last), 32'd0);
        checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("ram_we", 32'(ram_we), 32'd0);
        checkOutput("ram_regce", 32'(ram_regce), 32'd1);
        @(posedge clk);
        #1;
        rstb   = 1'b0;
        mon_en = 1'b1;

        // Four words from address 5 at full rate
        ready_mode = 0;
        resetCounters();
        applyStimulus(5, 4);
        waitDone(1, 200);
        checkOutput("t1_reads", 32'(reads_cnt), 32'd4);
        checkOutput("t1_pops", 32'(pops_cnt), 32'd4);
        checkOutput("t1_back_to_back", 32'(last_pop_cyc - first_pop_cyc), 32'd3);
        checkOutput("t1_last_count", 32'(last_cnt), 32'd1);

        // Address wrap at the top of RAM
        resetCounters();
        applyStimulus(MEM_SIZE - 2, 4);
        waitDone(1, 200);
        checkOutput("wrap_reads", 32'(reads_cnt), 32'd4);
        checkOutput("wrap_pops", 32'(pops_cnt), 32'd4);

        // Empty command
        resetCounters();
        applyStimulus(77, 0);
        waitDone(1, 50);
        checkOutput("len0_reads", 32'(reads_cnt), 32'd0);
        checkOutput("len0_valid", 32'(valid_cnt), 32'd0);

        // Consumer stalled for 20 cycles
        ready_mode = 2;
        resetCounters();
        applyStimulus(100, 8);
        repeat (20) @(posedge clk);
        checkOutput("stall_reads_bounded", 32'(reads_cnt <= FIFO_DEPTH), 32'd1);
        checkOutput("stall_no_pops", 32'(pops_cnt), 32'd0);
        ready_mode = 0;
        waitDone(1, 200);
        checkOutput("stall_total_reads", 32'(reads_cnt), 32'd8);
        checkOutput("stall_total_pops", 32'(pops_cnt), 32'd8);

        // Long command under random back-pressure
        ready_mode = 1;
        resetCounters();
        applyStimulus($urandom_range(0, MEM_SIZE - 1), 100);
        waitDone(1, 3000);
        checkOutput("long_pops", 32'(pops_cnt), 32'd100);
        checkOutput("long_last_count", 32'(last_cnt), 32'd1);

        // Back-to-back random commands offered while the block is busy
        resetCounters();
        for (int k = 0; k < 8; k++) begin
            applyStimulus($urandom_range(0, MEM_SIZE - 1), $urandom_range(0, 12));
        end
        waitDone(8, 3000);
        checkOutput("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset one cycle after the third read of a 10-word command
        ready_mode = 0;
        resetCounters();
        applyStimulus(200, 10);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (reads_cnt >= 3) begin
                break;
            end
        end
        checkOutput("mid_rst_reads", 32'(reads_cnt), 32'd3);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        rstb = 1'b0;
        resetCounters();
        repeat (6) begin
            @(negedge clk);
            checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
            checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        checkOutput("post_rst_pops", 32'(pops_cnt), 32'd0);
        resetCounters();
        applyStimulus(300, 2);
        waitDone(1, 200);
        checkOutput("post_rst_cmd_pops", 32'(pops_cnt), 32'd2);
        checkOutput("post_rst_cmd_reads", 32'(reads_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
